// File: rtl/cmem_wr_arbiter.sv
// cmem_wr_arbiter: shares one layer-memory write port between NREQ FIFO-buffered requesters
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   req_valid  per-requester write request
//   req_ready  per-requester FIFO not full (from registered count only)
//   req_addr   packed addresses, requester k at [k*AW +: AW]
//   req_data   packed data,      requester k at [k*DW +: DW]
//   req_sel    packed selects,   requester k at [k*SW +: SW]
//   cwr        registered memory write strobe
//   caddr_wr   memory write address (holds last value when cwr=0)
//   cdata_wr   memory write data    (holds last value when cwr=0)
//   csel       memory select        (holds last value when cwr=0)
//   o_grant    one-hot source of the current cwr beat, 0 when cwr=0
//   o_busy     high while any FIFO is non-empty or a beat is on the port
//
// Build option: define CMEM_WR_ARB_FIXED_PRIO_EN for fixed lowest-index priority
// instead of round-robin.
module cmem_wr_arbiter #(
    parameter int NREQ  = 2,
    parameter int AW    = 12,
    parameter int DW    = 20,
    parameter int SW    = 3,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ*SW-1:0] req_sel,
    output logic               cwr,
    output logic [AW-1:0]      caddr_wr,
    output logic [DW-1:0]      cdata_wr,
    output logic [SW-1:0]      csel,
    output logic [NREQ-1:0]    o_grant,
    output logic               o_busy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int GW = $clog2(NREQ);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t          state, state_d;
    logic [AW-1:0]   amem [NREQ][DEPTH];
    logic [DW-1:0]   dmem [NREQ][DEPTH];
    logic [SW-1:0]   smem [NREQ][DEPTH];
    logic [PW-1:0]   wr_ptr [NREQ];
    logic [PW-1:0]   rd_ptr [NREQ];
    logic [CW-1:0]   count [NREQ];
    logic [NREQ-1:0] nonempty, push, pop;
    logic            found;
    logic [GW-1:0]   gidx;

    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            req_ready[k] = count[k] != CW'(DEPTH);
            nonempty[k]  = count[k] != '0;
        end
    end

    assign push  = req_valid & req_ready;
    assign found = |nonempty;
    assign pop   = {{(NREQ-1){1'b0}}, found} << gidx;

`ifdef CMEM_WR_ARB_FIXED_PRIO_EN
    // Descending scan so the lowest non-empty index is the last one written.
    always_comb begin
        gidx = '0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (nonempty[i]) gidx = GW'(i);
    end
`else
    logic [GW-1:0] rr_ptr;

    // Scan offsets from rr_ptr in descending order so the smallest offset wins.
    always_comb begin
        gidx = '0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (nonempty[(int'(rr_ptr) + i) % NREQ]) gidx = GW'((int'(rr_ptr) + i) % NREQ);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rr_ptr <= '0;
        else if (found)
            rr_ptr <= (int'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NREQ; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                count[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                if (push[k]) wr_ptr[k] <= wr_ptr[k] + 1'b1;
                if (pop[k])  rd_ptr[k] <= rd_ptr[k] + 1'b1;
                count[k] <= count[k] + CW'(push[k]) - CW'(pop[k]);
            end
        end
    end

    // Storage needs no reset: entries are only read once their count makes them valid.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NREQ; k++) begin
            if (push[k]) begin
                amem[k][wr_ptr[k]] <= req_addr[k*AW +: AW];
                dmem[k][wr_ptr[k]] <= req_data[k*DW +: DW];
                smem[k][wr_ptr[k]] <= req_sel[k*SW +: SW];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cwr      <= 1'b0;
            caddr_wr <= '0;
            cdata_wr <= '0;
            csel     <= '0;
            o_grant  <= '0;
        end else begin
            cwr     <= found;
            o_grant <= pop;
            if (found) begin
                caddr_wr <= amem[gidx][rd_ptr[gidx]];
                cdata_wr <= dmem[gidx][rd_ptr[gidx]];
                csel     <= smem[gidx][rd_ptr[gidx]];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_d;
    end

    // Empty FIFOs with no push means nothing is popped, so the output register
    // drains on this same edge and the block can go idle together with cwr.
    always_comb begin
        state_d = state;
        if (|push)
            state_d = ACTIVE;
        else if (!found)
            state_d = IDLE;
    end

    assign o_busy = state == ACTIVE;

endmodule

// File: tb/tb_cmem_wr_arbiter.sv
// tb_cmem_wr_arbiter: randomized and directed bench against a queue-based reference model
module tb_cmem_wr_arbiter;
    localparam int NREQ  = 2;
    localparam int AW    = 12;
    localparam int DW    = 20;
    localparam int SW    = 3;
    localparam int DEPTH = 4;
    localparam int OW    = AW + DW + SW + NREQ + 2;

`ifdef CMEM_WR_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*AW-1:0] req_addr = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [NREQ*SW-1:0] req_sel = '0;
    logic               cwr;
    logic [AW-1:0]      caddr_wr;
    logic [DW-1:0]      cdata_wr;
    logic [SW-1:0]      csel;
    logic [NREQ-1:0]    o_grant;
    logic               o_busy;

    always #5 clk = ~clk;

    cmem_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .SW(SW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_sel(req_sel),
        .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .csel(csel),
        .o_grant(o_grant), .o_busy(o_busy)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [SW-1:0] s;
    } beat_t;

    // Reference model: one queue per requester, the port holds the last written beat.
    beat_t           mq [NREQ][$];
    int              m_last;
    logic            exp_cwr, exp_busy;
    beat_t           exp_b;
    logic [NREQ-1:0] exp_grant, acc;
    int              n_tests = 0;
    int              n_fail = 0;

    function automatic logic [NREQ-1:0] m_ready();
        logic [NREQ-1:0] r;
        for (int k = 0; k < NREQ; k++) r[k] = mq[k].size() < DEPTH;
        return r;
    endfunction

    function automatic int m_pick();
        if (FIXED) begin
            for (int k = 0; k < NREQ; k++) if (mq[k].size() > 0) return k;
        end else begin
            for (int off = 1; off <= NREQ; off++) begin
                int k;
                k = (m_last + off) % NREQ;
                if (mq[k].size() > 0) return k;
            end
        end
        return -1;
    endfunction

    function automatic logic [OW-1:0] obs();
        return {cwr, caddr_wr, cdata_wr, csel, o_grant, o_busy};
    endfunction

    function automatic logic [OW-1:0] expv();
        return {exp_cwr, exp_b.a, exp_b.d, exp_b.s, exp_grant, exp_busy};
    endfunction

    function automatic beat_t cur_beat(int k);
        beat_t b;
        b.a = req_addr[k*AW +: AW];
        b.d = req_data[k*DW +: DW];
        b.s = req_sel[k*SW +: SW];
        return b;
    endfunction

    task automatic set_beat(int k, int a);
        req_addr[k*AW +: AW] = AW'(a);
        req_data[k*DW +: DW] = DW'($urandom);
        req_sel[k*SW +: SW]  = SW'($urandom);
    endtask

    // Advance one clock and the model with it; outputs are sampled 1 time unit after the edge.
    task automatic cycle();
        logic [NREQ-1:0] rdy;
        int g;
        rdy = m_ready();
        g = m_pick();
        @(posedge clk);
        if (g >= 0) begin
            exp_b     = mq[g].pop_front();
            exp_cwr   = 1'b1;
            exp_grant = NREQ'(1) << g;
            m_last    = g;
        end else begin
            exp_cwr   = 1'b0;
            exp_grant = '0;
        end
        acc = req_valid & rdy;
        for (int k = 0; k < NREQ; k++) if (acc[k]) mq[k].push_back(cur_beat(k));
        exp_busy = exp_cwr;
        for (int k = 0; k < NREQ; k++) if (mq[k].size() > 0) exp_busy = 1'b1;
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        req_valid = '0;
        for (int k = 0; k < NREQ; k++) mq[k].delete();
        m_last = NREQ - 1;
        exp_cwr = 1'b0;
        exp_b = '0;
        exp_grant = '0;
        exp_busy = 1'b0;
        acc = '0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_tests++;
        if (cwr !== 1'b0 || o_busy !== 1'b0 || o_grant !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: cwr=%b busy=%b grant=%b, want 0 0 0", cwr, o_busy, o_grant);
        end
        n_tests++;
        if ({caddr_wr, cdata_wr, csel} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: addr=%h data=%h sel=%h, want zeros", caddr_wr, cdata_wr, csel);
        end
        n_tests++;
        if (req_ready !== {NREQ{1'b1}}) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want all ones", req_ready);
        end
    endtask

    task automatic test_single();
        apply_reset();
        req_valid[0] = 1'b1;
        req_addr[0 +: AW] = 12'h040;
        req_data[0 +: DW] = 20'h12345;
        req_sel[0 +: SW] = 3'd1;
        cycle();
        req_valid = '0;
        n_tests++;
        if (cwr !== 1'b0 || o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_lat1: cwr=%b busy=%b want 0 1", cwr, o_busy);
        end
        cycle();
        n_tests++;
        if ({cwr, caddr_wr, cdata_wr, csel, o_grant, o_busy} !== {1'b1, 12'h040, 20'h12345, 3'd1, 2'b01, 1'b1}) begin
            n_fail++;
            $display("FAIL single_write: cwr=%b addr=%h data=%h sel=%h grant=%b busy=%b want 1 040 12345 1 01 1",
                     cwr, caddr_wr, cdata_wr, csel, o_grant, o_busy);
        end
        cycle();
        n_tests++;
        if ({cwr, caddr_wr, cdata_wr, csel, o_grant, o_busy} !== {1'b0, 12'h040, 20'h12345, 3'd1, 2'b00, 1'b0}) begin
            n_fail++;
            $display("FAIL idle_hold: cwr=%b addr=%h data=%h sel=%h grant=%b busy=%b want 0 040 12345 1 00 0",
                     cwr, caddr_wr, cdata_wr, csel, o_grant, o_busy);
        end
    endtask

    task automatic test_contention();
        int idx [NREQ];
        int writes, reps, gaps, idle_run;
        logic [NREQ-1:0] lastg;
        bit started;
        apply_reset();
        idx = '{default: 0};
        writes = 0; reps = 0; gaps = 0; idle_run = 0; lastg = '0; started = 1'b0;
        for (int c = 0; c < 60; c++) begin
            for (int k = 0; k < NREQ; k++) begin
                req_valid[k] = idx[k] < 8;
                if (!acc[k] && c > 0) continue;
                set_beat(k, (k == 0 ? 0 : 'h400) + idx[k]);
            end
            n_tests++;
            if (req_ready !== m_ready()) begin
                n_fail++;
                $display("FAIL cont_ready c=%0d: got %b want %b", c, req_ready, m_ready());
            end
            cycle();
            for (int k = 0; k < NREQ; k++) if (acc[k]) idx[k]++;
            n_tests++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL cont_out c=%0d: got %h want %h", c, obs(), expv());
            end
            if (cwr) begin
                writes++;
                if (started && o_grant == lastg) reps++;
                if (started) gaps += idle_run;
                idle_run = 0;
                started = 1'b1;
                lastg = o_grant;
            end else idle_run++;
        end
        n_tests++;
        if (writes != 16 || reps != (FIXED ? 14 : 0) || gaps != 0) begin
            n_fail++;
            $display("FAIL cont_rotation: writes=%0d repeats=%0d gaps=%0d want 16 %0d 0", writes, reps, gaps, FIXED ? 14 : 0);
        end
    endtask

    task automatic test_backpressure();
        int sent1, r1_writes;
        bit stalled;
        apply_reset();
        sent1 = 0; r1_writes = 0; stalled = 1'b0;
        for (int c = 0; c < 50; c++) begin
            req_valid[0] = c < 24;
            req_valid[1] = sent1 < 6;
            if (acc[0] || c == 0) set_beat(0, c);
            if (acc[1] || c == 0) set_beat(1, 'h800 + sent1);
            if (req_valid[1] && !req_ready[1]) stalled = 1'b1;
            n_tests++;
            if (req_ready !== m_ready()) begin
                n_fail++;
                $display("FAIL bp_ready c=%0d: got %b want %b", c, req_ready, m_ready());
            end
            cycle();
            if (acc[1]) sent1++;
            if (cwr && o_grant[1]) r1_writes++;
            n_tests++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL bp_out c=%0d: got %h want %h", c, obs(), expv());
            end
        end
        n_tests++;
        if (r1_writes != 6 || stalled != FIXED) begin
            n_fail++;
            $display("FAIL bp_count: r1 writes=%0d stalled=%b want 6 %b", r1_writes, stalled, FIXED);
        end
    endtask

    task automatic test_full_pushpop();
        bit seen;
        apply_reset();
        seen = 1'b0;
        req_valid = '1;
        for (int c = 0; c < 14; c++) begin
            for (int k = 0; k < NREQ; k++) if (acc[k] || c == 0) set_beat(k, $urandom);
            if (mq[0].size() == DEPTH && m_pick() == 0) begin
                seen = 1'b1;
                n_tests++;
                if (req_ready[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL full_pop_ready c=%0d: got %b want 0", c, req_ready[0]);
                end
                cycle();
                n_tests++;
                if (req_ready[0] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL full_after_pop c=%0d: got %b want 1", c, req_ready[0]);
                end
            end else cycle();
            n_tests++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL full_out c=%0d: got %h want %h", c, obs(), expv());
            end
        end
        n_tests++;
        if (seen == FIXED) begin
            n_fail++;
            $display("FAIL full_reached: full-and-popped seen=%b want %b", seen, !FIXED);
        end
    endtask

    task automatic test_reset_mid();
        int stale;
        apply_reset();
        req_valid = '1;
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < NREQ; k++) set_beat(k, $urandom);
            cycle();
        end
        apply_reset();
        n_tests++;
        if (cwr !== 1'b0 || o_busy !== 1'b0 || req_ready !== {NREQ{1'b1}}) begin
            n_fail++;
            $display("FAIL rstmid_release: cwr=%b busy=%b ready=%b want 0 0 11", cwr, o_busy, req_ready);
        end
        stale = 0;
        for (int c = 0; c < 6; c++) begin
            cycle();
            if (cwr) stale++;
        end
        n_tests++;
        if (stale != 0 || obs() !== expv()) begin
            n_fail++;
            $display("FAIL rstmid_stale: writes=%0d out=%h want 0 %h", stale, obs(), expv());
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!req_valid[k] || acc[k]) begin
                    req_valid[k] = c < 560 && $urandom_range(99) < 60;
                    set_beat(k, $urandom);
                end
            end
            n_tests++;
            if (req_ready !== m_ready()) begin
                n_fail++;
                $display("FAIL rand_ready c=%0d: got %b want %b", c, req_ready, m_ready());
            end
            cycle();
            n_tests++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL rand_out c=%0d: got %h want %h", c, obs(), expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_full_pushpop();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cmem_wr_arbiter.md
Name: cmem_wr_arbiter

Overview:
- Shares the single layer-memory write port (cwr/caddr_wr/cdata_wr/csel) between NREQ independent write requesters, e.g. the convolution result stream and the max-pool result stream.
- Each requester has a private FIFO with a valid/ready handshake. A round-robin scheduler drains one entry per cycle to the memory port.
- Sits between the layer engines and the CONV top-level memory outputs, so that neither engine has to time-multiplex writes itself.

Parameters:
- NREQ, 2, number of requesters (2..4).
- AW, 12, write address width.
- DW, 20, write data width.
- SW, 3, memory select width.
- DEPTH, 4, entries per requester FIFO (power of 2, >= 2).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- req_valid  in  NREQ  per-requester write request.
- req_ready  out  NREQ  per-requester FIFO not full.
- req_addr  in  NREQ*AW  packed addresses; requester k at [k*AW +: AW].
- req_data  in  NREQ*DW  packed data; requester k at [k*DW +: DW].
- req_sel  in  NREQ*SW  packed selects; requester k at [k*SW +: SW].
- cwr  out  1  memory write strobe.
- caddr_wr  out  AW  memory write address.
- cdata_wr  out  DW  memory write data.
- csel  out  SW  memory select.
- o_grant  out  NREQ  one-hot source of the current cwr beat; 0 when cwr=0.
- o_busy  out  1  high while any FIFO is non-empty or cwr=1.

Behaviour:
- Reset (reset=0, async):
  - FIFOs empty; rr_ptr=0; state IDLE.
  - cwr=0, caddr_wr=0, cdata_wr=0, csel=0, o_grant=0, o_busy=0.
  - req_ready = all ones once reset is released.
  - Reset mid-operation discards all queued and in-flight beats; no cwr pulse follows release until a new push.
- Push:
  - Requester k is accepted on an edge where req_valid[k] & req_ready[k].
  - req_ready[k] = (count[k] != DEPTH), from registered count only. A full FIFO deasserts ready even if it is popped the same cycle (no bypass).
  - A push while ready=0 is ignored; the requester must hold the beat.
- Scheduling:
  - Each cycle, among non-empty FIFOs, grant the first index found scanning rr_ptr, rr_ptr+1, ... (mod NREQ).
  - Pop the granted head. On a grant, rr_ptr <= granted+1 mod NREQ; otherwise rr_ptr holds.
  - Push and pop on the same FIFO in the same cycle: count unchanged, ordering preserved.
- Output:
  - Registered. A beat popped in cycle t drives cwr=1 plus its addr/data/sel and o_grant in cycle t+1.
  - Latency: a beat pushed into an empty FIFO at edge E appears on cwr in the cycle after E+1 (2-cycle push-to-write).
  - Throughput: 1 write per cycle aggregate. With all FIFOs continuously non-empty, grants rotate strictly 0,1,..,NREQ-1.
  - When cwr=0, caddr_wr/cdata_wr/csel hold their last driven values; o_grant=0.
- State machine:
  - IDLE -> ACTIVE when any push is accepted.
  - ACTIVE -> IDLE when all FIFOs are empty, no push is accepted this cycle, and the last beat has left the output register.
  - o_busy = (state==ACTIVE), registered.
- Per-requester ordering is strictly FIFO. No ordering is guaranteed across requesters.
- Widths: all data paths are pass-through with no arithmetic. Counts are $clog2(DEPTH)+1 bits; pointers wrap modulo DEPTH.

Optional Feature:
- Macro CMEM_WR_ARB_FIXED_PRIO_EN.
- Defined: fixed priority replaces round-robin. The lowest-index non-empty FIFO always wins, rr_ptr is removed, and requester 0 may starve the others.
- Undefined: round-robin as specified above.

Test Plan:
- Single push: requester 0 pushes addr=0x040, data=0x12345, sel=1 into an empty arbiter. Two cycles later cwr=1, caddr_wr=0x040, cdata_wr=0x12345, csel=1, o_grant=01; o_busy falls the cycle after.
- Contention: both requesters push one beat per cycle for 8 cycles (r0 addr 0..7, r1 addr 0x400..0x407). cwr stays 1 continuously and o_grant alternates 01,10,...; per-requester addresses appear in order. With CMEM_WR_ARB_FIXED_PRIO_EN, all r0 beats precede r1 beats.
- Backpressure: r1 pushes 6 beats while r0 saturates the port under fixed priority. req_ready[1] drops after 4 accepted beats, and the held 5th beat is accepted only after a pop; no beat is lost or duplicated.
- Full push+pop: with FIFO 0 full and popped in the same cycle, ready[0]=0 that cycle. The next cycle ready[0]=1 and count=3.
- Reset mid-stream: reset=0 asserted with 3 beats queued. cwr=0, o_busy=0 and req_ready=11 immediately after release; no stale writes appear.
- Idle hold: after the last write, cwr=0 while caddr_wr, cdata_wr and csel remain at the last values and o_grant=00.
